// File: rtl/cpu_pkg.sv
// Shared constants for the 8-register CPU: opcodes, the NOP word and fetch FSM encodings.
package cpu_pkg;

  localparam int OP_SIZE  = 4;
  localparam int ARG_SIZE = 3;

  localparam logic [OP_SIZE-1:0] OP_LOAD  = 4'h0;
  localparam logic [OP_SIZE-1:0] OP_STORE = 4'h1;
  localparam logic [OP_SIZE-1:0] OP_ADD   = 4'h2;
  localparam logic [OP_SIZE-1:0] OP_SUB   = 4'h3;
  localparam logic [OP_SIZE-1:0] OP_AND   = 4'h4;
  localparam logic [OP_SIZE-1:0] OP_OR    = 4'h5;
  localparam logic [OP_SIZE-1:0] OP_NOT   = 4'h6;
  localparam logic [OP_SIZE-1:0] OP_MOV   = 4'h7;
  localparam logic [OP_SIZE-1:0] OP_BRN   = 4'h8;
  localparam logic [OP_SIZE-1:0] OP_LDPC  = 4'h9;
  localparam logic [OP_SIZE-1:0] OP_BXLR  = 4'hA;
  localparam logic [OP_SIZE-1:0] OP_NOP   = 4'hF;

  localparam logic [OP_SIZE+2*ARG_SIZE-1:0] NOP_INSTR = {OP_NOP, 3'b000, 3'b000};

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC and redirect-state select for the fetch sequencer.
module pc_next_sel #(
  parameter int ADDR_W = 6
) (
  input  logic              valid,
  input  logic              done,
  input  logic              branch,
  input  logic [ADDR_W-1:0] br_add,
  input  logic              bxlr,
  input  logic [ADDR_W-1:0] bus_tgt,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_inc,
  input  logic              redir_pend,
  input  logic [ADDR_W-1:0] redir_tgt,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic              redir_pend_nxt,
  output logic [ADDR_W-1:0] redir_tgt_nxt,
  output logic              refetch
);

  // Priority bxlr > done > lone branch > hold; nothing moves outside S_VALID.
  always_comb begin
    pc_nxt         = pc;
    redir_pend_nxt = redir_pend;
    redir_tgt_nxt  = redir_tgt;
    refetch        = 1'b0;
    if (valid) begin
      if (bxlr) begin
        pc_nxt         = bus_tgt;
        redir_pend_nxt = 1'b0;
        refetch        = 1'b1;
      end else if (done) begin
        if (branch)          pc_nxt = br_add;
        else if (redir_pend) pc_nxt = redir_tgt;
        else                 pc_nxt = pc_inc;
        redir_pend_nxt = 1'b0;
        refetch        = 1'b1;
      end else if (branch) begin
        redir_tgt_nxt  = br_add;
        redir_pend_nxt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack and presents words to the control FSM.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 6,
  parameter int                INSTR_W  = 10,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  br_add,
  input  logic               bxlr,
  input  logic [DATA_W-1:0]  bus_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [DATA_W-1:0]  pc_out,
  output fetch_state_t       dbg_state,
  output logic               dbg_redir_pend
);

  // Handshake: mem_req rises with mem_addr=pc and both stay stable until the cycle
  // mem_ack is high; that same cycle mem_rdata is captured and the request drops.

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [INSTR_W-1:0] ir;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_tgt;

  logic [ADDR_W-1:0] pc_nxt;
  logic              redir_pend_nxt;
  logic [ADDR_W-1:0] redir_tgt_nxt;
  logic              refetch;
  logic              bus_unused;

  // Only the low ADDR_W bits of the bus carry the return address.
  assign bus_unused = ^bus_in;
  assign pc_inc     = pc + 1'b1;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
    .valid          (state == S_VALID),
    .done           (done),
    .branch         (branch),
    .br_add         (br_add),
    .bxlr           (bxlr),
    .bus_tgt        (bus_in[ADDR_W-1:0]),
    .pc             (pc),
    .pc_inc         (pc_inc),
    .redir_pend     (redir_pend),
    .redir_tgt      (redir_tgt),
    .pc_nxt         (pc_nxt),
    .redir_pend_nxt (redir_pend_nxt),
    .redir_tgt_nxt  (redir_tgt_nxt),
    .refetch        (refetch)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      ir          <= '0;
      redir_pend  <= 1'b0;
      redir_tgt   <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      redir_pend <= redir_pend_nxt;
      redir_tgt  <= redir_tgt_nxt;
      case (state)
        S_BOOT: begin
          state   <= S_REQ;
          mem_req <= 1'b1;
        end
        S_REQ: begin
          if (mem_ack) begin
            ir          <= mem_rdata;
            state       <= S_VALID;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (refetch) begin
            state       <= S_REQ;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_BOOT;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr       = pc;
  assign instruction    = instr_valid ? ir : INSTR_W'(NOP_INSTR);
  assign pc_out         = DATA_W'(pc_inc);
  assign dbg_state      = state;
  assign dbg_redir_pend = redir_pend;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: table of fetch/strobe steps plus hand-written corner cases.
module tb_pc_fetch_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done = 1'b0, branch = 1'b0, bxlr = 1'b0, mem_ack = 1'b0;
  logic [5:0] br_add = '0;
  logic [7:0] bus_in = '0;
  logic [9:0] mem_rdata = '0;
  logic       mem_req, instr_valid, dbg_redir_pend;
  logic [5:0] mem_addr;
  logic [9:0] instruction;
  logic [7:0] pc_out;
  fetch_state_t dbg_state;

  logic [9:0] exp_q[$];
  int pass_cnt = 0;
  int total    = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .done(done), .branch(branch), .br_add(br_add),
    .bxlr(bxlr), .bus_in(bus_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc_out(pc_out), .dbg_state(dbg_state),
    .dbg_redir_pend(dbg_redir_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         delay;
    logic [9:0] word;
    logic [5:0] exp_addr;
    logic [7:0] exp_pc_out;
    logic       pre_br;
    logic [5:0] pre_add;
    logic       a_done;
    logic       a_branch;
    logic [5:0] a_br_add;
    logic       a_bxlr;
    logic [7:0] a_bus;
    logic [5:0] exp_next;
  } step_t;

  step_t steps[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) chk("req_timeout", 32'(mem_req), 32'd1);
  endtask

  task automatic do_fetch(input int delay, input logic [9:0] word,
                          input logic [5:0] exp_addr, input logic [7:0] exp_pc_out);
    wait_req();
    chk("fetch_addr", 32'(mem_addr), 32'(exp_addr));
    chk("pc_out", 32'(pc_out), 32'(exp_pc_out));
    repeat (delay) @(negedge clk);
    chk("req_hold", {31'd0, mem_req}, 32'd1);
    chk("addr_hold", 32'(mem_addr), 32'(exp_addr));
    mem_ack   = 1'b1;
    mem_rdata = word;
    exp_q.push_back(word);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 10'($urandom_range(0, 1023));
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    if (exp_q.size() > 0) chk("instruction", 32'(instruction), 32'(exp_q.pop_front()));
  endtask

  task automatic do_branch(input logic [5:0] tgt);
    branch = 1'b1;
    br_add = tgt;
    @(negedge clk);
    branch = 1'b0;
    br_add = 6'($urandom_range(0, 63));
    chk("br_hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("br_pend", {31'd0, dbg_redir_pend}, 32'd1);
  endtask

  task automatic do_action(input logic d, input logic b, input logic [5:0] ba,
                           input logic x, input logic [7:0] bus, input logic [5:0] exp_next);
    done = d; branch = b; br_add = ba; bxlr = x; bus_in = bus;
    @(negedge clk);
    done = 1'b0; branch = 1'b0; bxlr = 1'b0;
    chk("refetch_req", {31'd0, mem_req}, 32'd1);
    chk("refetch_invalid", {31'd0, instr_valid}, 32'd0);
    chk("refetch_nop", 32'(instruction), 32'h3C0);
    chk("next_addr", 32'(mem_addr), 32'(exp_next));
    chk("pend_clear", {31'd0, dbg_redir_pend}, 32'd0);
  endtask

  initial begin
    //           dly word    addr   pcout  pre   pre_add done br  br_add bxlr bus    next
    steps[0] = '{3, 10'h0A5, 6'h00, 8'h01, 1'b0, 6'h00,  1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 6'h01};
    steps[1] = '{0, 10'h111, 6'h01, 8'h02, 1'b0, 6'h00,  1'b0, 1'b0, 6'h00, 1'b1, 8'h05, 6'h05};
    steps[2] = '{2, 10'h2B4, 6'h05, 8'h06, 1'b1, 6'h20,  1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 6'h20};
    steps[3] = '{1, 10'h3A9, 6'h20, 8'h21, 1'b0, 6'h00,  1'b1, 1'b0, 6'h00, 1'b1, 8'h09, 6'h09};
    steps[4] = '{0, 10'h250, 6'h09, 8'h0A, 1'b0, 6'h00,  1'b1, 1'b1, 6'h11, 1'b0, 8'h00, 6'h11};
    steps[5] = '{4, 10'h0C3, 6'h11, 8'h12, 1'b0, 6'h00,  1'b0, 1'b0, 6'h00, 1'b1, 8'hFF, 6'h3F};
    steps[6] = '{1, 10'h1E7, 6'h3F, 8'h00, 1'b0, 6'h00,  1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 6'h00};
    steps[7] = '{0, 10'h3FE, 6'h00, 8'h01, 1'b0, 6'h00,  1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 6'h01};

    // Reset values while rst is held low
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", 32'(instruction), 32'h3C0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(S_BOOT));
    rst = 1'b1;
    @(negedge clk);
    chk("boot_to_req", {31'd0, mem_req}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_fetch(steps[i].delay, steps[i].word, steps[i].exp_addr, steps[i].exp_pc_out);
      if (steps[i].pre_br) do_branch(steps[i].pre_add);
      do_action(steps[i].a_done, steps[i].a_branch, steps[i].a_br_add,
                steps[i].a_bxlr, steps[i].a_bus, steps[i].exp_next);
    end

    // Strobes in S_REQ are ignored
    done = 1'b1; bxlr = 1'b1; bus_in = 8'h30; branch = 1'b1; br_add = 6'h22;
    @(negedge clk);
    done = 1'b0; bxlr = 1'b0; branch = 1'b0;
    chk("req_ignores_addr", 32'(mem_addr), 32'h01);
    chk("req_ignores_req", {31'd0, mem_req}, 32'd1);
    chk("req_ignores_pend", {31'd0, dbg_redir_pend}, 32'd0);
    do_fetch(0, 10'h2C3, 6'h01, 8'h02);

    // Stray ack in S_VALID does not overwrite ir
    mem_ack = 1'b1; mem_rdata = 10'h1FF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_instr", 32'(instruction), 32'h2C3);
    chk("stray_valid", {31'd0, instr_valid}, 32'd1);

    // Last of two branches wins
    do_branch(6'h2A);
    do_branch(6'h15);
    do_action(1'b1, 1'b0, 6'h00, 1'b0, 8'h00, 6'h15);

    // Asynchronous reset mid-fetch with ack pending
    mem_ack = 1'b1; mem_rdata = 10'h155;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", 32'(instruction), 32'h3C0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(S_BOOT));
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    chk("arst_no_capture", {31'd0, instr_valid}, 32'd0);
    do_fetch(1, 10'h0F0, 6'h00, 8'h01);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
